mul_arbiter: RTL and testbench

Shares one `multiplier` instance between NREQ requesters with valid/ready handshakes and round-robin arbitration. Accepted operand pairs go through a two-stage pipeline: operand register, then the combinational multiplier, then a result register. Each result is returned on a single response port tagged with the requester index. The block sits between the vector-lane front ends and the single shared multiplier datapath.

---
 rtl/mul_pkg.sv | 19 +
 rtl/multiplier.sv | 18 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/mul_arbiter.sv | 86 ++++++++
 tb/tb_mul_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared constants, tag-width helper and operand record for the shared multiplier.
package mul_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_NREQ  = 4;

   function automatic int clog2(input int n);
      clog2 = 0;
      for (int i = 0; (1 << i) < n; i++) clog2 = i + 1;
   endfunction

   typedef struct packed {
      logic [DEF_WIDTH-1:0]       a;
      logic [DEF_WIDTH-1:0]       b;
      logic                       sign;
      logic [clog2(DEF_NREQ)-1:0] id;
   } mul_op_t;

endpackage

// File: rtl/multiplier.sv
// multiplier: combinational WIDTH x WIDTH multiply, signed or unsigned per operation.
module multiplier #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               sign,
   output logic [2*WIDTH-1:0] product
);

   logic [2*WIDTH-1:0] ax, bx;

   // Extending both operands to 2*WIDTH makes the truncated product exact for either signedness.
   assign ax      = sign ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
   assign bx      = sign ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
   assign product = ax * bx;

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr_i with wrap.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   // Scanning from the farthest offset down lets the nearest valid requester overwrite the result.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_i[(int'(ptr_i) + k) % N]) begin
            gnt_o                             = '0;
            gnt_o[(int'(ptr_i) + k) % N]      = 1'b1;
            idx_o                             = IW'((int'(ptr_i) + k) % N);
         end
      end
   end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one multiplier among NREQ requesters,
// operand register -> multiplier -> result register, results tagged with requester id.
module mul_arbiter
   import mul_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = DEF_NREQ,
   parameter int IDW   = clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_sign,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [2*WIDTH-1:0]    rsp_product
);

   logic [NREQ-1:0]    gnt;
   logic [IDW-1:0]     gidx, rr_q, rr_d;
   logic               adv1, adv2, acc;
   logic               s1_valid_q, s1_sign_q, s2_valid_q;
   logic [WIDTH-1:0]   s1_a_q, s1_b_q;
   logic [IDW-1:0]     s1_id_q, s2_id_q;
   logic [2*WIDTH-1:0] prod, s2_product_q;

   rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
      .req_i (req_valid),
      .ptr_i (rr_q),
      .gnt_o (gnt),
      .idx_o (gidx)
   );

   multiplier #(.WIDTH(WIDTH)) u_mul (
      .a       (s1_a_q),
      .b       (s1_b_q),
      .sign    (s1_sign_q),
      .product (prod)
   );

   assign adv2      = !s2_valid_q || rsp_ready;
   assign adv1      = !s1_valid_q || adv2;
   // Gated by rst_n so nothing looks accepted while reset is held.
   assign req_ready = gnt & {NREQ{adv1 && rst_n}};
   assign acc       = |req_ready;
   assign rr_d      = acc ? ((gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1) : rr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_q         <= '0;
         s1_valid_q   <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_sign_q    <= 1'b0;
         s1_id_q      <= '0;
         s2_valid_q   <= 1'b0;
         s2_product_q <= '0;
         s2_id_q      <= '0;
      end else begin
         rr_q <= rr_d;
         if (adv1) begin
            s1_valid_q <= acc;
            if (acc) begin
               s1_a_q    <= req_a[gidx*WIDTH +: WIDTH];
               s1_b_q    <= req_b[gidx*WIDTH +: WIDTH];
               s1_sign_q <= req_sign[gidx];
               s1_id_q   <= gidx;
            end
         end
         if (adv2) begin
            s2_valid_q   <= s1_valid_q;
            s2_product_q <= prod;
            s2_id_q      <= s1_id_q;
         end
      end
   end

   assign rsp_valid   = s2_valid_q;
   assign rsp_product = s2_product_q;
   assign rsp_id      = s2_id_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed vectors plus hand-written sequences for fairness, backpressure and reset.
module tb_mul_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid, req_ready, req_sign;
   logic [31:0] req_a, req_b;
   logic        rsp_valid, rsp_ready;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_product;
   int          n_cmp = 0;
   int          n_bad = 0;

   typedef struct {
      int          id;
      logic [7:0]  a;
      logic [7:0]  b;
      logic        s;
      logic [15:0] p;
   } vec_t;

   vec_t v[10];

   mul_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_sign    (req_sign),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_product (rsp_product)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      v[0] = '{0, 8'd42,  8'd42,  1'b1, 16'd1764};
      v[1] = '{1, 8'hD6,  8'd7,   1'b1, 16'hFEDA};
      v[2] = '{2, 8'hD6,  8'd7,   1'b0, 16'd1498};
      v[3] = '{3, 8'h80,  8'h80,  1'b1, 16'd16384};
      v[4] = '{0, 8'hFF,  8'hFF,  1'b0, 16'd65025};
      v[5] = '{1, 8'h00,  8'h9C,  1'b1, 16'd0};
      v[6] = '{2, 8'hFF,  8'h01,  1'b1, 16'hFFFF};
      v[7] = '{3, 8'h7F,  8'h80,  1'b1, 16'hC080};
      v[8] = '{0, 8'h80,  8'hFF,  1'b0, 16'h7F80};
      v[9] = '{1, 8'h80,  8'hFF,  1'b1, 16'h0080};

      rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 4'hF; req_sign = '0; req_a = '0; req_b = '0;
      tick; tick;
      chk("reset_ready", 32'(req_ready), 0);
      chk("reset_valid", 32'(rsp_valid), 0);
      chk("reset_id", 32'(rsp_id), 0);
      chk("reset_prod", 32'(rsp_product), 0);
      req_valid = '0; rst_n = 1'b1;
      tick;

      for (int i = 0; i < 10; i++) begin
         req_a = '0; req_b = '0; req_sign = '0;
         req_a[v[i].id*8 +: 8] = v[i].a;
         req_b[v[i].id*8 +: 8] = v[i].b;
         req_sign[v[i].id]     = v[i].s;
         req_valid             = 4'(1 << v[i].id);
         #1;
         chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(1 << v[i].id));
         tick;
         req_valid = '0;
         chk($sformatf("vec%0d_early", i), 32'(rsp_valid), 0);
         tick;
         chk($sformatf("vec%0d_valid", i), 32'(rsp_valid), 1);
         chk($sformatf("vec%0d_id", i), 32'(rsp_id), 32'(v[i].id));
         chk($sformatf("vec%0d_prod", i), 32'(rsp_product), 32'(v[i].p));
         tick;
      end

      // back-to-back signed then unsigned from different requesters
      req_a = '0; req_b = '0;
      req_a[15:8] = 8'hD6; req_b[15:8] = 8'd7; req_a[23:16] = 8'hD6; req_b[23:16] = 8'd7;
      req_sign = 4'b0010; req_valid = 4'b0010;
      #1 chk("mix_ready1", 32'(req_ready), 32'b0010);
      tick;
      req_valid = 4'b0100;
      #1 chk("mix_ready2", 32'(req_ready), 32'b0100);
      tick;
      req_valid = '0;
      chk("mix_r1_valid", 32'(rsp_valid), 1);
      chk("mix_r1_id", 32'(rsp_id), 1);
      chk("mix_r1_prod", 32'(rsp_product), 32'hFEDA);
      tick;
      chk("mix_r2_valid", 32'(rsp_valid), 1);
      chk("mix_r2_id", 32'(rsp_id), 2);
      chk("mix_r2_prod", 32'(rsp_product), 32'd1498);
      tick;
      chk("mix_drained", 32'(rsp_valid), 0);

      // fairness from a freshly reset pointer; requester i computes (i+1)*3
      rst_n = 1'b0; tick; rst_n = 1'b1;
      req_sign = '0;
      for (int i = 0; i < 4; i++) begin
         req_a[i*8 +: 8] = 8'(i + 1);
         req_b[i*8 +: 8] = 8'd3;
      end
      req_valid = 4'hF;
      #1;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("fair%0d_ready", k), 32'(req_ready), 32'(1 << (k % 4)));
         if (k >= 2) begin
            chk($sformatf("fair%0d_valid", k), 32'(rsp_valid), 1);
            chk($sformatf("fair%0d_id", k), 32'(rsp_id), 32'((k - 2) % 4));
            chk($sformatf("fair%0d_prod", k), 32'(rsp_product), 32'(((k - 2) % 4 + 1) * 3));
         end
         tick;
      end
      req_valid = '0;
      chk("fair_tail0_id", 32'(rsp_id), 0);
      chk("fair_tail0_prod", 32'(rsp_product), 3);
      tick;
      chk("fair_tail1_id", 32'(rsp_id), 1);
      chk("fair_tail1_prod", 32'(rsp_product), 6);
      tick;
      chk("fair_empty", 32'(rsp_valid), 0);

      // backpressure: pointer now at 2, so ids 2 then 3 are taken and then the pipe is full
      rsp_ready = 1'b0; req_valid = 4'hF;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp%0d_ready", k), 32'(req_ready), (k == 0) ? 32'b0100 : (k == 1) ? 32'b1000 : 0);
         if (k >= 2) begin
            chk($sformatf("bp%0d_valid", k), 32'(rsp_valid), 1);
            chk($sformatf("bp%0d_id", k), 32'(rsp_id), 2);
            chk($sformatf("bp%0d_prod", k), 32'(rsp_product), 9);
         end
         tick;
      end
      req_valid = '0; rsp_ready = 1'b1;
      #1;
      chk("bp_rel_ready", 32'(req_ready), 0);
      chk("bp_rel0_id", 32'(rsp_id), 2);
      tick;
      chk("bp_rel1_valid", 32'(rsp_valid), 1);
      chk("bp_rel1_id", 32'(rsp_id), 3);
      chk("bp_rel1_prod", 32'(rsp_product), 12);
      tick;
      chk("bp_nodup", 32'(rsp_valid), 0);

      // fill both stages from requester 1 (pointer moves to 2), then reset
      rsp_ready = 1'b0; req_valid = 4'b0010;
      tick; tick;
      req_valid = '0;
      chk("mid_full_valid", 32'(rsp_valid), 1);
      chk("mid_full_ready", 32'(req_ready), 0);
      rst_n = 1'b0;
      tick;
      chk("mid_rst_valid", 32'(rsp_valid), 0);
      chk("mid_rst_id", 32'(rsp_id), 0);
      chk("mid_rst_prod", 32'(rsp_product), 0);
      rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 4'b1010;
      #1;
      chk("mid_first_grant", 32'(req_ready), 32'b0010);
      tick;
      req_valid = '0;
      tick;
      chk("mid_post_valid", 32'(rsp_valid), 1);
      chk("mid_post_id", 32'(rsp_id), 1);
      chk("mid_post_prod", 32'(rsp_product), 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
